// File: rtl/map_scheduler.sv
// Map-step sequencer: speed-dependent move_map pulse plus obstacle/objective row selection.
// Outputs are combinational from registered state (same-cycle); no backpressure, generate_map takes every pulse.
module map_scheduler #(
   parameter int TICK_BASE   = 1250000,
   parameter int MIN_GAP_OBS = 8,
   parameter int MIN_GAP_OBJ = 12
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        stop,
   input  logic        pause_toggle,
   input  logic [1:0]  speed_level,
   input  logic        obstacle_generated,
   input  logic        objective_generated,
   output logic        move_map,
   output logic        sel_obstacle,
   output logic        sel_objective,
   output logic        running,
   output logic [15:0] step_count
);

   localparam int PW = $clog2(TICK_BASE + 1);
   localparam logic [PW-1:0] TICK_BASE_W = PW'(TICK_BASE);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t        state, state_nxt;
   logic          enter_run;
   logic [PW-1:0] tick_cnt;
   logic [PW-1:0] period;
   logic [PW-1:0] period_sel;
   logic [7:0]    gap_obs;
   logic [7:0]    gap_obj;
   logic [7:0]    lfsr;
   logic [3:0]    thr;

   assign period_sel = TICK_BASE_W >> speed_level;

   // stop outranks start/pause_toggle; start only counts from IDLE
   always_comb begin
      state_nxt = state;
      enter_run = 1'b0;
      case (state)
         IDLE: begin
            if (start && !stop) begin
               state_nxt = RUN;
               enter_run = 1'b1;
            end
         end
         RUN: begin
            if (stop)              state_nxt = IDLE;
            else if (pause_toggle) state_nxt = PAUSE;
         end
         PAUSE: begin
            if (stop)              state_nxt = IDLE;
            else if (pause_toggle) state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      running  = (state == RUN);
      move_map = (state == RUN) && (tick_cnt == period - PW'(1));
      case (speed_level)
         2'd0:    thr = 4'd4;
         2'd1:    thr = 4'd6;
         2'd2:    thr = 4'd8;
         default: thr = 4'd10;
      endcase
      // obstacle wins when both rows would qualify on the same step
      sel_obstacle  = move_map && (gap_obs >= 8'(MIN_GAP_OBS)) && (lfsr[3:0] < thr);
      sel_objective = move_map && (gap_obj >= 8'(MIN_GAP_OBJ)) && (lfsr[7:4] < 4'd6)
                      && !sel_obstacle;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         tick_cnt   <= '0;
         period     <= TICK_BASE_W;
         gap_obs    <= 8'hFF;
         gap_obj    <= 8'hFF;
         lfsr       <= 8'hA5;
         step_count <= '0;
      end else begin
         state <= state_nxt;
         lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

         // period is only re-sampled at a step boundary so speed changes never split a step
         if (enter_run) begin
            tick_cnt   <= '0;
            step_count <= '0;
            period     <= period_sel;
         end else if (move_map) begin
            tick_cnt   <= '0;
            period     <= period_sel;
            step_count <= step_count + 16'd1;
         end else if (state == RUN) begin
            tick_cnt   <= tick_cnt + PW'(1);
         end

         if (enter_run) begin
            gap_obs <= 8'hFF;
            gap_obj <= 8'hFF;
         end else begin
            if (obstacle_generated)               gap_obs <= 8'h00;
            else if (move_map && gap_obs != 8'hFF) gap_obs <= gap_obs + 8'd1;
            if (objective_generated)              gap_obj <= 8'h00;
            else if (move_map && gap_obj != 8'hFF) gap_obj <= gap_obj + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_map_scheduler.sv
// Scoreboard bench for map_scheduler: stimulus queues expected step cycles/counts, a negedge monitor checks them.
module tb_map_scheduler;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic        stop;
   logic        pause_toggle;
   logic [1:0]  speed_level;
   logic        obstacle_generated;
   logic        objective_generated;
   logic        move_map;
   logic        sel_obstacle;
   logic        sel_objective;
   logic        running;
   logic [15:0] step_count;

   map_scheduler #(.TICK_BASE(16), .MIN_GAP_OBS(2), .MIN_GAP_OBJ(3)) dut (
      .clock               (clock),
      .reset_n             (reset_n),
      .start               (start),
      .stop                (stop),
      .pause_toggle        (pause_toggle),
      .speed_level         (speed_level),
      .obstacle_generated  (obstacle_generated),
      .objective_generated (objective_generated),
      .move_map            (move_map),
      .sel_obstacle        (sel_obstacle),
      .sel_objective       (sel_objective),
      .running             (running),
      .step_count          (step_count)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int at;
      int step;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   starts_issued = 0;
   bit   fb_en = 1'b1;

   task automatic chk(input string name, input int act, input int expv);
      n_chk++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
   endtask

   task automatic push_exp(input int at, input int step);
      exp_t e;
      e.at   = at;
      e.step = step;
      exp_q.push_back(e);
   endtask

   // returns #1 after the posedge that brings cyc to n; inputs set here are sampled at edge n+1
   task automatic at_cyc(input int n);
      while (cyc < n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // generate_map stand-in: pulses feedback the cycle after a selected row while fb_en is set
   initial begin : fb_drv
      bit want_o, want_j;
      obstacle_generated  = 1'b0;
      objective_generated = 1'b0;
      forever begin
         @(negedge clock);
         want_o = fb_en && move_map && sel_obstacle;
         want_j = fb_en && move_map && sel_objective;
         @(posedge clock);
         #1;
         obstacle_generated  = want_o;
         objective_generated = want_j;
      end
   end

   // reference for the row decision: LFSR and gap counters as they will stand after the next edge
   logic [7:0] m_lfsr = 8'hA5;
   logic [7:0] m_gobs = 8'hFF;
   logic [7:0] m_gobj = 8'hFF;
   int         starts_seen = 0;
   bit         pend_vld = 1'b0;
   int         pend_step = 0;
   int         since_obs = 255;
   bit         prev_obs_nofb = 1'b0;
   int         nofb_pairs = 0;

   always @(negedge clock) begin : monitor
      exp_t       e;
      logic [3:0] thr;
      bit         e_obs, e_obj;

      if (pend_vld) begin
         chk("step_count", int'(step_count), pend_step);
         pend_vld = 1'b0;
      end
      if (obstacle_generated) since_obs = 0;

      if (move_map) begin
         case (speed_level)
            2'd0:    thr = 4'd4;
            2'd1:    thr = 4'd6;
            2'd2:    thr = 4'd8;
            default: thr = 4'd10;
         endcase
         e_obs = (m_gobs >= 8'd2) && (m_lfsr[3:0] < thr);
         e_obj = (m_gobj >= 8'd3) && (m_lfsr[7:4] < 4'd6) && !e_obs;
         chk("sel_obstacle", int'(sel_obstacle), int'(e_obs));
         chk("sel_objective", int'(sel_objective), int'(e_obj));
         chk("sel_exclusive", int'(sel_obstacle && sel_objective), 0);
         if (sel_obstacle) chk("obstacle_spacing_violated", int'(since_obs < 2), 0);
         if (!fb_en) begin
            if (sel_obstacle && prev_obs_nofb) nofb_pairs++;
            prev_obs_nofb = sel_obstacle;
         end
         if (exp_q.size() == 0) begin
            chk("unexpected_move_map", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("move_map_cycle", cyc, e.at);
            pend_step = e.step;
            pend_vld  = 1'b1;
         end
         if (since_obs < 255) since_obs++;
      end else begin
         chk("sel_without_move_map", int'(sel_obstacle || sel_objective), 0);
      end

      if (!reset_n) begin
         m_lfsr = 8'hA5;
         m_gobs = 8'hFF;
         m_gobj = 8'hFF;
      end else begin
         m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
         if (starts_seen != starts_issued) begin
            starts_seen = starts_issued;
            m_gobs = 8'hFF;
            m_gobj = 8'hFF;
         end else begin
            if (obstacle_generated)               m_gobs = 8'h00;
            else if (move_map && m_gobs != 8'hFF) m_gobs = m_gobs + 8'd1;
            if (objective_generated)              m_gobj = 8'h00;
            else if (move_map && m_gobj != 8'hFF) m_gobj = m_gobj + 8'd1;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
      $fatal(1);
   end

   initial begin : stim
      reset_n      = 1'b0;
      start        = 1'b0;
      stop         = 1'b0;
      pause_toggle = 1'b0;
      speed_level  = 2'd0;

      at_cyc(2);
      @(negedge clock);
      chk("reset_move_map", int'(move_map), 0);
      chk("reset_sel_obstacle", int'(sel_obstacle), 0);
      chk("reset_sel_objective", int'(sel_objective), 0);
      chk("reset_running", int'(running), 0);
      chk("reset_step_count", int'(step_count), 0);
      reset_n = 1'b1;

      // speed 0: steps every 16 cycles, first on the 16th cycle after start
      at_cyc(4);
      start = 1'b1;
      starts_issued++;
      push_exp(20, 1);
      push_exp(36, 2);
      push_exp(52, 3);
      at_cyc(5);
      start = 1'b0;
      @(negedge clock);
      chk("running_after_start", int'(running), 1);

      // pause with 5 ticks done: 51 frozen edges, then 10 more ticks to the step
      at_cyc(57);
      pause_toggle = 1'b1;
      push_exp(119, 4);
      at_cyc(58);
      pause_toggle = 1'b0;
      at_cyc(80);
      @(negedge clock);
      chk("running_in_pause", int'(running), 0);
      at_cyc(108);
      pause_toggle = 1'b1;
      at_cyc(109);
      pause_toggle = 1'b0;
      at_cyc(110);
      @(negedge clock);
      chk("running_after_resume", int'(running), 1);

      // speed 3 mid-period: step 5 keeps period 16, then every 2 cycles
      at_cyc(124);
      speed_level = 2'd3;
      push_exp(135, 5);
      for (int k = 6; k <= 45; k++) push_exp(137 + 2 * (k - 6), k);

      // from step 26 on generate_map gives no feedback (empty ROM pattern)
      at_cyc(176);
      fb_en = 1'b0;

      // stop and pause_toggle together go to IDLE
      at_cyc(216);
      stop         = 1'b1;
      pause_toggle = 1'b1;
      at_cyc(217);
      stop         = 1'b0;
      pause_toggle = 1'b0;
      @(negedge clock);
      chk("running_after_stop", int'(running), 0);
      at_cyc(220);
      pause_toggle = 1'b1;
      at_cyc(221);
      pause_toggle = 1'b0;
      at_cyc(224);
      speed_level = 2'd0;
      @(negedge clock);
      chk("pause_in_idle_ignored", int'(running), 0);

      // restart, then reset halfway through the first period: no step may appear
      at_cyc(226);
      start = 1'b1;
      starts_issued++;
      at_cyc(227);
      start = 1'b0;
      @(negedge clock);
      chk("running_restart", int'(running), 1);
      at_cyc(234);
      reset_n = 1'b0;
      at_cyc(235);
      @(negedge clock);
      chk("midrun_reset_move_map", int'(move_map), 0);
      chk("midrun_reset_sel_obstacle", int'(sel_obstacle), 0);
      chk("midrun_reset_sel_objective", int'(sel_objective), 0);
      chk("midrun_reset_running", int'(running), 0);
      chk("midrun_reset_step_count", int'(step_count), 0);
      reset_n = 1'b1;

      at_cyc(290);
      @(negedge clock);
      chk("idle_after_reset_running", int'(running), 0);
      chk("idle_after_reset_step_count", int'(step_count), 0);
      chk("missing_move_maps", exp_q.size(), 0);
      chk("nofb_back_to_back_obstacle_seen", int'(nofb_pairs > 0), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
